// File: rtl/ttl_arb_pkg.sv
// Shared definitions for the TTL-style round-robin arbiter.
// Contents: arbiter state encoding and the wrap-around increment used to
// advance the priority pointer.
package ttl_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Next index modulo 'modulus' (0 follows modulus-1).
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned modulus);
    return (idx + 32'd1 >= modulus) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/ttl_arb_pick.sv
// Rotating priority encoder: returns the first active-low request found
// searching upward from 'pointer', wrapping modulo WIDTH_OUT.
// Ports:
//   request_bar  in   active-low request vector
//   pointer      in   search start index
//   exclude      in   skip the last slot of the search (index pointer-1,
//                     i.e. the current grantee when pointer = grantee+1)
//   valid        out  a request was found
//   index        out  index of the winning request (0 when !valid)
module ttl_arb_pick
  import ttl_arb_pkg::*;
#(
  parameter int unsigned WIDTH_OUT = 4,
  parameter int unsigned WIDTH_IN  = $clog2(WIDTH_OUT)
) (
  input  logic [WIDTH_OUT-1:0] request_bar,
  input  logic [WIDTH_IN-1:0]  pointer,
  input  logic                 exclude,
  output logic                 valid,
  output logic [WIDTH_IN-1:0]  index
);

  int unsigned cand;

  // Walk offsets 0..WIDTH_OUT-1 from the pointer; first hit wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = 32'(pointer);
    for (int unsigned off = 0; off < WIDTH_OUT; off++) begin
      if (!valid && !(exclude && off == WIDTH_OUT - 1) && !request_bar[WIDTH_IN'(cand)]) begin
        valid = 1'b1;
        index = WIDTH_IN'(cand);
      end
      cand = wrap_inc(cand, WIDTH_OUT);
    end
  end

endmodule

// File: rtl/ttl_rr_arbiter.sv
// Round-robin arbiter with active-low (TTL style) requests and grants.
// The grant is presented both encoded (Grant_index, suitable as demux
// select lines) and decoded (Grant_bar, one-of-N active-low).
// Optional build macro: TTL_ARB_TIMEOUT_EN adds a tenure counter that forces
// rotation after HOLD_MAX grant cycles when another requester is waiting.
// DELAY_RISE/DELAY_FALL are board-level timing annotations; outputs here are
// ideal registers.
// Ports:
//   Clk          in   rising-edge clock
//   Clear        in   synchronous active-high reset
//   Enable_bar   in   active-low arbiter enable
//   Request_bar  in   active-low request per requester
//   Grant_bar    out  active-low one-hot grant, all ones = no grant
//   Grant_index  out  encoded index of current/last grantee
//   Busy         out  high while a grant is held
module ttl_rr_arbiter
  import ttl_arb_pkg::*;
#(
  parameter int unsigned WIDTH_OUT  = 4,
  parameter int unsigned WIDTH_IN   = $clog2(WIDTH_OUT),
  parameter int unsigned HOLD_MAX   = 8,
  parameter int          DELAY_RISE = 0,
  parameter int          DELAY_FALL = 0
) (
  input  logic                 Clk,
  input  logic                 Clear,
  input  logic                 Enable_bar,
  input  logic [WIDTH_OUT-1:0] Request_bar,
  output logic [WIDTH_OUT-1:0] Grant_bar,
  output logic [WIDTH_IN-1:0]  Grant_index,
  output logic                 Busy
);

  // Parameter sanity hook; intentionally empty when parameters are legal.
  if (HOLD_MAX == 0 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_params
  end

  arb_state_e           state_q, state_d;
  logic [WIDTH_IN-1:0]  ptr_q, ptr_d;
  logic [WIDTH_IN-1:0]  idx_q, idx_d;
  logic [WIDTH_OUT-1:0] grant_bar_q, grant_bar_d;
  logic                 busy_q, busy_d;

  logic [WIDTH_IN-1:0]  next_ptr;
  logic [WIDTH_IN-1:0]  pick_ptr;
  logic                 pick_excl;
  logic                 pick_valid;
  logic [WIDTH_IN-1:0]  pick_index;
  logic                 timeout;

  // Pointer value that follows the current grantee.
  assign next_ptr = WIDTH_IN'(wrap_inc(32'(idx_q), WIDTH_OUT));

  // While granting, search starts past the grantee and never returns it.
  assign pick_ptr  = (state_q == ARB_GRANT) ? next_ptr : ptr_q;
  assign pick_excl = (state_q == ARB_GRANT);

  ttl_arb_pick #(
    .WIDTH_OUT (WIDTH_OUT),
    .WIDTH_IN  (WIDTH_IN)
  ) u_pick (
    .request_bar (Request_bar),
    .pointer     (pick_ptr),
    .exclude     (pick_excl),
    .valid       (pick_valid),
    .index       (pick_index)
  );

`ifdef TTL_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Tenure expires on the edge that completes HOLD_MAX grant cycles.
  assign timeout = (32'(cnt_q) + 32'd1 >= HOLD_MAX);

  // Restart on any new grant, otherwise count up and saturate.
  always_comb begin
    cnt_d = '0;
    if (state_d == ARB_GRANT && state_q == ARB_GRANT && idx_d == idx_q) begin
      cnt_d = (32'(cnt_q) >= HOLD_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state, pointer and registered-output values.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (!Enable_bar && pick_valid) begin
          state_d = ARB_GRANT;
          idx_d   = pick_index;
        end
      end
      ARB_GRANT: begin
        if (Enable_bar) begin
          state_d = ARB_IDLE;
        end else if (Request_bar[idx_q]) begin
          // Release: advance pointer and hand off without a bubble cycle.
          ptr_d = next_ptr;
          if (pick_valid) begin
            idx_d = pick_index;
          end else begin
            state_d = ARB_IDLE;
          end
        end else if (timeout && pick_valid) begin
          ptr_d = next_ptr;
          idx_d = pick_index;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    busy_d = (state_d == ARB_GRANT);
    for (int unsigned i = 0; i < WIDTH_OUT; i++) begin
      grant_bar_d[i] = !(busy_d && idx_d == WIDTH_IN'(i));
    end
  end

  always_ff @(posedge Clk) begin
    if (Clear) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      grant_bar_q <= '1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      grant_bar_q <= grant_bar_d;
      busy_q      <= busy_d;
    end
  end

  assign Grant_bar   = grant_bar_q;
  assign Grant_index = idx_q;
  assign Busy        = busy_q;

endmodule
